wb_burst_master: RTL and testbench
==================================

Name: wb_burst_master

Overview:
- Synthesizable Wishbone B4 initiator that drives the SDRAM controller's Wishbone slave port (cyc/stb/we/addr/dat/sel/cti, ack/dat_o).
- Converts a simple command (address, length, direction) plus write/read data streams into incrementing-burst Wishbone cycles.
- Replaces the behavioural bus driver as the traffic source for SDRAM regressions and on-chip BIST.

Parameters:
- AW, 32, Wishbone byte-address width.
- DW, 32, Wishbone data width; a multiple of 8.
- LENW, 8, width of the burst-length field; maximum burst is 2^LENW-1 beats.
- TIMEOUT, 255, cycles with stb high and no ack before the cycle is aborted; must be at least 1.

Ports:
- wb_clk_i  in  1  system clock; every flop is on the rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  start byte address; must be DW/8-aligned.
- cmd_len  in  LENW  number of beats; 0 is treated as 1.
- cmd_sel  in  DW/8  byte enables applied to every beat.
- wdata  in  DW  write-data stream payload.
- wdata_valid  in  1  write-data stream valid.
- wdata_ready  out  1  write word popped when wdata_valid && wdata_ready.
- rdata  out  DW  captured read data.
- rdata_valid  out  1  one-cycle pulse per read beat.
- done  out  1  one-cycle pulse when a burst ends, normally or by abort.
- err  out  1  qualifies done: 1 = the burst was aborted by timeout.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls.
- wb_addr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  Wishbone byte select.
- wb_cti_o  out  3  Wishbone cycle-type identifier.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  DW  slave read data.

Behaviour:
- Reset:
  - When wb_rst_i is high at a clock edge, every output goes to 0 on that edge, except cmd_ready, which goes to 1.
  - State returns to IDLE, counters clear, and no done pulse is generated.
  - Reset mid-burst drops cyc/stb immediately; the slave sees an aborted cycle.
- All Wishbone outputs are registered.
- States are IDLE, WRITE, READ, FINISH.
- IDLE:
  - cmd_ready=1.
  - On accept: latch addr, len (0→1), sel and we; set wb_cyc_o=1 and wb_we_o=cmd_we; go to WRITE or READ.
- Beat acceptance: a beat is accepted on any edge where wb_stb_o && wb_ack_i. The slave may ack on consecutive cycles.
- wb_cti_o:
  - 3'b111 when the beat on the bus is the last beat.
  - 3'b010 otherwise.
  - A 1-beat burst therefore presents 3'b111.
- READ:
  - wb_stb_o=1 on the first cycle after accept.
  - Each accepted beat registers rdata<=wb_dat_i and pulses rdata_valid the following cycle.
  - wb_addr_o advances by DW/8 on each accept.
  - stb stays high until the last beat is accepted.
- WRITE:
  - wdata_ready = (state==WRITE) && (!wb_stb_o || wb_ack_i) && (popped < len).
  - On a pop: wb_dat_o<=wdata, wb_stb_o<=1, and the address advances except on the first pop.
  - On an accept with no pop, wb_stb_o<=0 and cyc is held; the master inserts wait states while the stream is empty.
- Leaving a burst: after the last accepted beat, cyc, stb and cti are cleared and the state moves to FINISH. FINISH pulses done=1 with err=0 for one cycle, then returns to IDLE.
- Timeout:
  - A counter clears on every ack and whenever stb is low, and increments while stb && !ack.
  - When it reaches TIMEOUT, cyc and stb drop, and done=1 with err=1 pulses for one cycle.
  - Unpopped write words are left in the stream; the state returns to IDLE.
- Address arithmetic is modulo 2^AW; wrap-around is silent.
- wb_sel_o is held at cmd_sel for the whole burst.
- cmd_ready=0 from accept until the cycle after done.
- Simultaneous last-beat ack and timeout expiry: the ack wins; err=0.

Test Plan:
- Write 4 beats, cmd_addr=0x100, sel=4'hF, wdata 0xA0..0xA3, slave acks each cycle. Required: addresses 0x100/104/108/10C; cti 010,010,010,111; done=1, err=0 one cycle after the last ack.
- Read back the same 4 beats with 1-cycle slave latency. Required: rdata_valid fires 4 times with 0xA0..0xA3 in order; cyc low after the last ack.
- Write 3 beats with wdata_valid gapped 2 cycles between words. Required: stb deasserts during the gaps, cyc stays high, exactly 3 acks, done once.
- cmd_len=0 read at 0xFFFFFFFC. Required: a single beat with cti=111; no address wrap observed; done=1.
- Slave never acks, TIMEOUT=8. Required: cyc/stb drop after 8 stalled cycles; done=1 with err=1; cmd_ready returns to 1.
- Assert wb_rst_i during beat 2 of an 8-beat write. Required: the next edge has cyc=stb=0, no done pulse, cmd_ready=1; a new command completes normally.

Source files
------------

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst initiator: turns a command plus write/read
// data streams into classic burst cycles with a stalled-beat timeout.
module wb_burst_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [DW-1:0]     wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DW-1:0]     rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // WRITE  | write burst: pop stream words, present them, count acks
  // READ   | read burst: stb held, capture data on each ack
  // FINISH | bus released, done pulse visible; cmd_ready returns next

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [AW-1:0] STEP = AW'(DW / 8);
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  state_t          state;
  logic [LENW:0]   len_q;
  logic [LENW:0]   popped;
  logic [LENW:0]   acked;
  logic [TW-1:0]   timer;

  logic beat, last_beat, pop, expire;

  assign beat        = wb_stb_o && wb_ack_i;
  assign last_beat   = beat && ((acked + (LENW+1)'(1)) == len_q);
  assign wdata_ready = (state == WRITE) && (!wb_stb_o || wb_ack_i) && (popped < len_q);
  assign pop         = wdata_valid && wdata_ready;
  // An ack on the expiring cycle suppresses the abort.
  assign expire      = wb_stb_o && !wb_ack_i && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      len_q       <= '0;
      popped      <= '0;
      acked       <= '0;
      timer       <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_cti_o    <= 3'b000;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (!wb_stb_o || wb_ack_i) timer <= '0;
      else                       timer <= timer + TW'(1);

      if (beat && (state == READ)) begin
        rdata       <= wb_dat_i;
        rdata_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            wb_cyc_o  <= 1'b1;
            wb_we_o   <= cmd_we;
            wb_addr_o <= cmd_addr;
            wb_sel_o  <= cmd_sel;
            len_q     <= (cmd_len == '0) ? (LENW+1)'(1) : {1'b0, cmd_len};
            popped    <= '0;
            acked     <= '0;
            if (cmd_we) begin
              state <= WRITE;
            end else begin
              state    <= READ;
              wb_stb_o <= 1'b1;
              wb_cti_o <= (cmd_len <= LENW'(1)) ? CTI_END : CTI_INC;
            end
          end
        end

        WRITE: begin
          if (last_beat) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cti_o <= 3'b000;
            done     <= 1'b1;
            state    <= FINISH;
          end else begin
            if (beat) acked <= acked + (LENW+1)'(1);
            if (pop) begin
              wb_dat_o <= wdata;
              wb_stb_o <= 1'b1;
              // The first word goes out at the command address itself.
              if (popped != '0) wb_addr_o <= wb_addr_o + STEP;
              popped   <= popped + (LENW+1)'(1);
              wb_cti_o <= ((popped + (LENW+1)'(1)) == len_q) ? CTI_END : CTI_INC;
            end else if (beat) begin
              wb_stb_o <= 1'b0;
            end
            if (expire) begin
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              wb_cti_o <= 3'b000;
              done     <= 1'b1;
              err      <= 1'b1;
              state    <= FINISH;
            end
          end
        end

        READ: begin
          if (last_beat) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cti_o <= 3'b000;
            done     <= 1'b1;
            state    <= FINISH;
          end else if (beat) begin
            acked     <= acked + (LENW+1)'(1);
            wb_addr_o <= wb_addr_o + STEP;
            wb_cti_o  <= ((acked + (LENW+1)'(2)) == len_q) ? CTI_END : CTI_INC;
          end else if (expire) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cti_o <= 3'b000;
            done     <= 1'b1;
            err      <= 1'b1;
            state    <= FINISH;
          end
        end

        FINISH: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: behavioural Wishbone slave, write-stream source
// and an arithmetic burst model; directed scenarios plus randomized bursts.
module tb_wb_burst_master;

  localparam int AW = 32, DW = 32, LENW = 8, TMO = 8;

  logic              clk = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic              cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0]     cmd_addr = '0;
  logic [LENW-1:0]   cmd_len = '0;
  logic [DW/8-1:0]   cmd_sel = '0;
  logic [DW-1:0]     wdata = '0;
  logic              wdata_valid = 1'b0;
  logic              wb_ack_i = 1'b0;
  logic [DW-1:0]     wb_dat_i = '0;
  logic              cmd_ready, wdata_ready, rdata_valid, done, err;
  logic [DW-1:0]     rdata, wb_dat_o;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0]     wb_addr_o;
  logic [DW/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;

  always #5 clk = ~clk;

  wb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  cti;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          cyc;
  } beat_t;

  beat_t       slog[$];
  logic [31:0] smem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] wq[$];
  logic [31:0] rq[$];

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc_n = 0;
  int lat = 0;
  bit no_ack = 1'b0;
  int wait_cnt = 0;
  int gap_min = 0, gap_max = 0, gap_cnt = 0;
  logic fire_q = 1'b0;
  int done_cnt = 0, err_cnt = 0, rv_cnt = 0, stb_hi = 0, cyc_fall = 0, gap_cyc = 0;
  logic prev_cyc = 1'b0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hDEAD_0000 ^ a;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave: acks after `lat` wait cycles, word-wide memory.
  always @(negedge clk) begin
    beat_t b;
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
    if (wb_cyc_o && wb_stb_o && !no_ack) begin
      if (wait_cnt >= lat) begin
        b.addr = wb_addr_o; b.cti = wb_cti_o; b.we = wb_we_o;
        b.sel = wb_sel_o; b.cyc = cyc_n;
        if (wb_we_o) begin
          smem[wb_addr_o] = wb_dat_o;
          b.dat = wb_dat_o;
        end else begin
          wb_dat_i = smem.exists(wb_addr_o) ? smem[wb_addr_o] : dflt(wb_addr_o);
          b.dat = wb_dat_i;
        end
        slog.push_back(b);
        wb_ack_i = 1'b1;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Write-data stream source with configurable gaps between words.
  always @(posedge clk) fire_q <= wdata_valid && wdata_ready;
  always @(negedge clk) begin
    if (fire_q && wq.size() > 0) begin
      void'(wq.pop_front());
      gap_cnt = $urandom_range(gap_max, gap_min);
    end
    if (gap_cnt > 0) begin
      wdata_valid = 1'b0;
      gap_cnt--;
    end else if (wq.size() > 0) begin
      wdata_valid = 1'b1;
      wdata = wq[0];
    end else begin
      wdata_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (err) err_cnt++;
    end
    if (rdata_valid) begin
      rv_cnt++;
      rq.push_back(rdata);
    end
    if (wb_stb_o) stb_hi++;
    if (wb_cyc_o && !wb_stb_o) gap_cyc++;
    if (prev_cyc && !wb_cyc_o) cyc_fall++;
    prev_cyc = wb_cyc_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_cmd(input bit we, input logic [31:0] a, input logic [7:0] l,
                           input logic [3:0] s);
    int k;
    k = 0;
    while (!cmd_ready && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_we = we; cmd_addr = a; cmd_len = l; cmd_sel = s; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  // Full burst with model-derived expectations for every beat.
  task automatic run_burst(input bit we, input logic [31:0] a, input logic [7:0] l,
                           input logic [3:0] s, input bit fixed, input logic [31:0] dbase,
                           input string tag);
    int n, d0, e0, r0, done_cyc;
    logic [31:0] exp_d[$];
    logic [31:0] ba, d;
    n = (l == 0) ? 1 : int'(l);
    slog.delete();
    rq.delete();
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(4 * i);
      if (we) begin
        d = fixed ? dbase + 32'(i) : $urandom;
        wq.push_back(d);
        exp_d.push_back(d);
        model_mem[ba] = d;
      end else begin
        exp_d.push_back(model_mem.exists(ba) ? model_mem[ba] : dflt(ba));
      end
    end
    d0 = done_cnt; e0 = err_cnt; r0 = rv_cnt;
    issue_cmd(we, a, l, s);
    wait_done(tag);
    done_cyc = cyc_n;
    check({tag, "_err"}, err, 0);
    check({tag, "_cyc_low_at_done"}, {wb_cyc_o, wb_stb_o}, 0);
    check({tag, "_cmd_ready_during_done"}, cmd_ready, 0);
    @(posedge clk); #1;
    check({tag, "_cmd_ready_after_done"}, cmd_ready, 1);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_err_cnt"}, err_cnt - e0, 0);
    check({tag, "_beats"}, slog.size(), n);
    check({tag, "_rvalid_cnt"}, rv_cnt - r0, we ? 0 : n);
    if (slog.size() > 0)
      check({tag, "_done_latency"}, done_cyc - slog[slog.size()-1].cyc, 1);
    for (int i = 0; i < n && i < slog.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), slog[i].addr, a + 32'(4 * i));
      check($sformatf("%s_cti%0d", tag, i), slog[i].cti, (i == n - 1) ? 3'b111 : 3'b010);
      check($sformatf("%s_we_sel%0d", tag, i), {slog[i].we, slog[i].sel}, {we, s});
      check($sformatf("%s_dat%0d", tag, i), slog[i].dat, exp_d[i]);
      if (!we && i < rq.size())
        check($sformatf("%s_rdata%0d", tag, i), rq[i], exp_d[i]);
    end
  endtask

  initial begin
    int s0, g0, f0, d0, e0;
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [3:0]  rs;

    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_sel_o}, 0);
    check("reset_addr_dat", {wb_addr_o, wb_dat_o}, 0);
    check("reset_flags", {done, err, rdata_valid, wdata_ready}, 0);
    wb_rst_i = 1'b0;

    lat = 0;
    run_burst(1'b1, 32'h100, 8'd4, 4'hF, 1'b1, 32'hA0, "wr4");
    lat = 1;
    run_burst(1'b0, 32'h100, 8'd4, 4'hF, 1'b0, 32'h0, "rd4");

    lat = 0; gap_min = 2; gap_max = 2;
    g0 = gap_cyc; f0 = cyc_fall;
    run_burst(1'b1, 32'h300, 8'd3, 4'h3, 1'b0, 32'h0, "wrgap");
    check("wrgap_cyc_held", cyc_fall - f0, 1);
    check("wrgap_stb_gaps", (gap_cyc - g0) >= 4, 1);
    gap_min = 0; gap_max = 0;

    run_burst(1'b0, 32'hFFFF_FFFC, 8'd0, 4'hF, 1'b0, 32'h0, "rdlen0");

    no_ack = 1'b1;
    slog.delete();
    s0 = stb_hi; e0 = err_cnt;
    issue_cmd(1'b0, 32'h200, 8'd2, 4'hF);
    wait_done("tmo_rd");
    check("tmo_rd_err", err, 1);
    check("tmo_rd_bus_dropped", {wb_cyc_o, wb_stb_o}, 0);
    @(posedge clk); #1;
    check("tmo_rd_cmd_ready", cmd_ready, 1);
    check("tmo_rd_stall_cycles", stb_hi - s0, TMO);
    check("tmo_rd_no_beats", slog.size(), 0);
    check("tmo_rd_err_cnt", err_cnt - e0, 1);

    for (int i = 0; i < 4; i++) wq.push_back(32'h5500 + 32'(i));
    issue_cmd(1'b1, 32'h400, 8'd4, 4'hF);
    wait_done("tmo_wr");
    check("tmo_wr_err", err, 1);
    check("tmo_wr_words_left", wq.size(), 3);
    wq.delete();
    @(posedge clk); #1;
    check("tmo_wr_cmd_ready", cmd_ready, 1);
    no_ack = 1'b0;

    slog.delete();
    for (int i = 0; i < 8; i++) wq.push_back(32'h7700 + 32'(i));
    issue_cmd(1'b1, 32'h800, 8'd8, 4'hF);
    for (int k = 0; k < 200 && slog.size() < 1; k++) begin
      @(posedge clk); #1;
    end
    check("rst_burst_started", slog.size() >= 1, 1);
    wb_rst_i = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    check("rst_mid_bus", {wb_cyc_o, wb_stb_o, wb_cti_o}, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_flags", {done, err, wdata_ready}, 0);
    wq.delete();
    wb_rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 0);
    run_burst(1'b1, 32'h900, 8'd2, 4'hC, 1'b0, 32'h0, "post_rst");

    for (int it = 0; it < 6; it++) begin
      ra = 32'h1000 + 32'($urandom_range(63, 0) * 4);
      rl = 8'($urandom_range(6, 0));
      rs = 4'($urandom_range(15, 1));
      gap_max = $urandom_range(2, 0);
      lat = $urandom_range(2, 0);
      run_burst(1'b1, ra, rl, rs, 1'b0, 32'h0, $sformatf("rnd_wr%0d", it));
      gap_max = 0;
      lat = $urandom_range(2, 0);
      run_burst(1'b0, ra, rl, rs, 1'b0, 32'h0, $sformatf("rnd_rd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
